// File: rtl/uart_sort_ctrl.sv
// Frame collector between a UART and an external sorter: gathers N bytes, launches the sort,
// then streams the sorted frame back out to the transmitter.
module uart_sort_ctrl #(
    parameter int unsigned N            = 8,
    parameter int unsigned W            = 8,
    parameter int unsigned SORT_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_valid,
    input  logic [W-1:0]   rx_data,
    output logic           sort_start,
    output logic [N*W-1:0] sort_dout,
    input  logic           sort_done,
    input  logic [N*W-1:0] sort_din,
    output logic           tx_valid,
    output logic [W-1:0]   tx_data,
    input  logic           tx_ready,
    output logic           busy,
    output logic           overrun,
    output logic           timeout
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(SORT_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [CW-1:0] EXPIRE_CNT = CW'(SORT_TIMEOUT - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_SEND  = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [IW-1:0] idx;
    logic [W-1:0]  frame_buf [N];
    logic [CW-1:0] wait_cnt;
    logic          rx_take;
    logic          tx_take;
    logic          sort_expire;

    assign rx_take     = (state_q == S_FILL) && rx_valid;
    assign tx_take     = (state_q == S_SEND) && tx_ready;
    assign sort_expire = (state_q == S_WAIT) && !sort_done && (wait_cnt == EXPIRE_CNT);

    // Status/strobe outputs are pure decodes of the state register.
    assign sort_start = (state_q == S_START);
    assign tx_valid   = (state_q == S_SEND);
    assign busy       = (state_q != S_FILL);
    assign tx_data    = frame_buf[idx];

    always_comb begin
        sort_dout = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sort_dout[W*i +: W] = frame_buf[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (rx_take && (idx == LAST_IDX)) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (sort_done) begin
                    state_d = S_SEND;
                end else if (sort_expire) begin
                    state_d = S_FILL;
                end
            end
            S_SEND:  if (tx_take && (idx == LAST_IDX)) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // Datapath: idx wraps naturally at N because N is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            wait_cnt <= '0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            if (rx_valid && (state_q != S_FILL)) begin
                overrun <= 1'b1;
            end
            if (rx_take) begin
                frame_buf[idx] <= rx_data;
                idx            <= IW'(idx + 1'b1);
            end
            if (state_q == S_START) begin
                wait_cnt <= '0;
            end
            if (state_q == S_WAIT) begin
                wait_cnt <= CW'(wait_cnt + 1'b1);
                if (sort_done) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        frame_buf[i] <= sort_din[W*i +: W];
                    end
                end else if (sort_expire) begin
                    timeout <= 1'b1;
                end
            end
            if (tx_take) begin
                idx <= IW'(idx + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_uart_sort_ctrl.sv
// Scoreboard bench for uart_sort_ctrl: random frames, a behavioural sorter, and a monitor
// that checks every sort launch and every transmitted byte against a reference model.
module tb_uart_sort_ctrl;

    localparam int unsigned NB = 8;
    localparam int unsigned WB = 8;
    localparam int unsigned TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [WB-1:0] rx_data;
    logic          sort_start;
    logic [63:0]   sort_dout;
    logic          sort_done;
    logic [63:0]   sort_din;
    logic          tx_valid;
    logic [WB-1:0] tx_data;
    logic          tx_ready;
    logic          busy;
    logic          overrun;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    int sorter_en = 1;
    int sorter_delay = 5;
    int starts_seen = 0;
    int exp_starts = 0;
    int last_start_cyc = 0;
    int last_rx_cyc = 0;
    int tx_rise_cyc = 0;

    logic [63:0]   exp_frame_q [$];
    logic [WB-1:0] exp_tx_q [$];

    uart_sort_ctrl #(.N(NB), .W(WB), .SORT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .sort_start(sort_start), .sort_dout(sort_dout), .sort_done(sort_done),
        .sort_din(sort_din), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference sort: emit values in ascending order by scanning the whole byte range.
    function automatic logic [63:0] sort_frame(input logic [63:0] f);
        logic [63:0] s;
        int k;
        s = '0;
        k = 0;
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < 8; i++) begin
                if (f[8*i +: 8] == 8'(v)) begin
                    s[8*k +: 8] = f[8*i +: 8];
                    k++;
                end
            end
        end
        return s;
    endfunction

    function automatic logic [63:0] rand_frame();
        return {$urandom, $urandom};
    endfunction

    task automatic send_byte(input logic [WB-1:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        last_rx_cyc = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f, input bit expect_tx, input int max_gap);
        logic [63:0] s;
        exp_frame_q.push_back(f);
        exp_starts++;
        if (expect_tx) begin
            s = sort_frame(f);
            for (int i = 0; i < 8; i++) exp_tx_q.push_back(s[8*i +: 8]);
        end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk); #1;
            end
            send_byte(f[8*i +: 8]);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_tx_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(n < budget), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sort_start"}, 64'(sort_start), 64'd0);
        chk({tag, "_sort_dout"}, sort_dout, 64'd0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero(tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Transmitter model: ready always, alternating, or random.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Behavioural sorter: answers sort_start after sorter_delay cycles with the sorted frame.
    initial begin
        logic [63:0] seen;
        int d;
        sort_done = 1'b0;
        sort_din  = '0;
        forever begin
            @(negedge clk);
            if (rst && sort_start && sorter_en != 0) begin
                seen = sort_dout;
                d = sorter_delay;
                repeat (d) @(posedge clk);
                #1;
                sort_done = 1'b1;
                sort_din  = sort_frame(seen);
                @(posedge clk); #1;
                sort_done = 1'b0;
                sort_din  = {$urandom, $urandom};
            end
        end
    end

    // Monitor: checks each sort launch and each byte handed to the transmitter.
    initial begin
        logic prev_start, prev_txv, prev_rdy;
        logic [WB-1:0] prev_data;
        prev_start = 1'b0;
        prev_txv = 1'b0;
        prev_rdy = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_start = 1'b0;
                prev_txv = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (sort_start) begin
                    starts_seen++;
                    last_start_cyc = cyc;
                    if (prev_start) chk("sort_start_pulse", 64'd2, 64'd1);
                    if (exp_frame_q.size() == 0) chk("sort_start_unexpected", 64'd1, 64'd0);
                    else chk("sort_dout", sort_dout, exp_frame_q.pop_front());
                end
                if (tx_valid && prev_txv && !prev_rdy) chk("tx_hold", 64'(tx_data), 64'(prev_data));
                if (tx_valid && !prev_txv) tx_rise_cyc = cyc;
                if (tx_valid && tx_ready) begin
                    if (exp_tx_q.size() == 0) chk("tx_extra", 64'(tx_data), 64'hdead);
                    else chk("tx_data", 64'(tx_data), 64'(exp_tx_q.pop_front()));
                end
                prev_start = sort_start;
                prev_txv = tx_valid;
                prev_rdy = tx_ready;
                prev_data = tx_data;
            end
        end
    end

    initial begin
        int n;
        logic [63:0] f;
        logic [WB-1:0] fixed_order [8];
        fixed_order = '{8'h00, 8'h07, 8'h10, 8'h33, 8'h41, 8'h41, 8'h5A, 8'hFF};
        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed frame, ready held high, sorter 5 cycles.
        send_frame({8'h41, 8'h00, 8'hFF, 8'h10, 8'h33, 8'h07, 8'h5A, 8'h41}, 1'b0, 0);
        for (int i = 0; i < 8; i++) exp_tx_q.push_back(fixed_order[i]);
        wait_done("drain_fixed", 200);
        chk("latency", 64'(tx_rise_cyc - last_rx_cyc), 64'(2 + 5));
        chk("one_start", 64'(starts_seen), 64'd1);
        chk("no_overrun", 64'(overrun), 64'd0);

        // Stalling transmitter.
        ready_mode = 1;
        send_frame(rand_frame(), 1'b1, 1);
        wait_done("drain_toggle", 300);

        // Byte arriving while the sorter works.
        ready_mode = 0;
        sorter_delay = 20;
        send_frame(rand_frame(), 1'b1, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("overrun_pre_wait", 64'(overrun), 64'd0);
        send_byte(8'hA5);
        chk("overrun_wait", 64'(overrun), 64'd1);
        wait_done("drain_ovr_wait", 300);
        sorter_delay = 4;
        send_frame(rand_frame(), 1'b1, 0);
        wait_done("drain_after_ovr", 300);

        // Byte arriving while the frame is being transmitted.
        do_reset("reset2");
        ready_mode = 1;
        send_frame(rand_frame(), 1'b1, 0);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_reached", 64'(tx_valid), 64'd1);
        send_byte(8'h3C);
        chk("overrun_send", 64'(overrun), 64'd1);
        wait_done("drain_ovr_send", 300);

        // Reset in the middle of a frame.
        ready_mode = 0;
        for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h70));
        do_reset("reset_mid");
        send_frame(rand_frame(), 1'b1, 0);
        wait_done("drain_post_reset", 300);

        // Randomized traffic.
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            sorter_delay = $urandom_range(10, 1);
            send_frame(rand_frame(), 1'b1, 2);
            wait_done("drain_rand", 400);
        end

        // Sorter answers on the last permitted WAIT cycle.
        ready_mode = 0;
        sorter_delay = TO;
        send_frame(rand_frame(), 1'b1, 0);
        wait_done("drain_edge", TO + 200);
        chk("timeout_edge_done", 64'(timeout), 64'd0);

        // Sorter never answers.
        sorter_en = 0;
        send_frame(rand_frame(), 1'b0, 0);
        n = 0;
        while (!timeout && n < TO + 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 64'(cyc - last_start_cyc), 64'(TO + 1));
        @(posedge clk); #1;
        chk("timeout_idle", 64'(busy), 64'd0);

        // Sorter answers one cycle too late; the stray done lands in FILL.
        sorter_en = 1;
        sorter_delay = TO + 1;
        send_frame(rand_frame(), 1'b0, 0);
        wait_done("drain_late", TO + 200);
        repeat (5) begin
            @(posedge clk); #1;
        end
        sorter_delay = 3;
        f = rand_frame();
        send_frame(f, 1'b1, 1);
        wait_done("drain_recover", 300);
        chk("timeout_sticky", 64'(timeout), 64'd1);

        chk("start_count", 64'(starts_seen), 64'(exp_starts));
        chk("frames_left", 64'(exp_frame_q.size()), 64'd0);
        chk("bytes_left", 64'(exp_tx_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_sort_ctrl.md
UART_SORT_CTRL -- requirements
Module: uart_sort_ctrl

Interface
REQ-001 Parameter N, default 8: bytes per frame; power of 2, >= 2.
REQ-002 Parameter W, default 8: byte width in bits.
REQ-003 Parameter SORT_TIMEOUT, default 1024: maximum clk cycles to wait for sort_done; >= 2.
REQ-004 clk  input  1  single clock, rising-edge active.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 rx_valid  input  1  one-cycle strobe: received byte on rx_data.
REQ-007 rx_data  input  W  received byte; valid when rx_valid=1.
REQ-008 sort_start  output  1  one-cycle pulse that launches the sorter.
REQ-009 sort_dout  output  N*W  unsorted frame to sorter; slot i at bits [W*i +: W].
REQ-010 sort_done  input  1  one-cycle strobe: sort_din holds the sorted result.
REQ-011 sort_din  input  N*W  sorted frame from sorter; same slot packing as sort_dout.
REQ-012 tx_valid  output  1  byte available for the UART transmitter.
REQ-013 tx_data  output  W  byte to transmit.
REQ-014 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-015 busy  output  1  high whenever the FSM is not in FILL.
REQ-016 overrun  output  1  sticky flag: a received byte was dropped.
REQ-017 timeout  output  1  sticky flag: sorter missed its SORT_TIMEOUT deadline.

Function
REQ-018 The FSM SHALL have the states FILL, START, WAIT and SEND; a shared index idx (log2 N bits) and an N-entry W-bit buffer are used.
REQ-019 FILL: each rx_valid SHALL write rx_data to buf[idx] and increment idx; the first byte of a frame goes to slot 0.
REQ-020 FILL: the rx_valid that fills slot N-1 SHALL set idx to 0 and move to START on the next cycle.
REQ-021 START: sort_start SHALL be 1 for exactly this one cycle; next state WAIT; the wait counter clears.
REQ-022 sort_dout SHALL continuously reflect buf and SHALL stay stable from START until WAIT exits.
REQ-023 WAIT: on sort_done=1, sort_din SHALL be captured into buf and the next state is SEND.
REQ-024 WAIT: the counter SHALL increment each cycle; if it reaches SORT_TIMEOUT without sort_done, timeout SHALL set, the frame is discarded, and the next state is FILL.
REQ-025 sort_done in the expiry cycle SHALL take priority over the timeout (result captured, timeout not set).
REQ-026 sort_done outside WAIT SHALL be ignored.
REQ-027 SEND: tx_valid=1 and tx_data=buf[idx]; a transfer occurs on tx_valid&&tx_ready, then idx increments.
REQ-028 SEND: tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-029 SEND: the transfer of slot N-1 SHALL set idx=0, drop tx_valid the next cycle, and return to FILL.
REQ-030 rx_valid in any state other than FILL SHALL drop the byte and set overrun; buf and idx are unaffected.
REQ-031 overrun and timeout SHALL be cleared only by reset.
REQ-032 busy SHALL be combinational on state (0 in FILL, 1 otherwise).
REQ-033 Throughput: the first byte is sent at latency of 2 cycles plus sorter latency after the final rx_valid; 1 byte/cycle with tx_ready held at 1.

Reset
REQ-034 While rst=0, state SHALL be FILL, idx 0, buf all 0, wait counter 0, and all outputs 0 (including sort_dout, which reflects buf).
REQ-035 Reset asserted mid-frame in any state SHALL abandon the frame immediately with no further sort_start or tx_valid.

Verification
REQ-036 Send bytes 0x41,0x5A,0x07,0x33,0x10,0xFF,0x00,0x41 with a model sorter (done 5 cycles after start) -> exactly one sort_start; sort_dout slot0=0x41; tx order is 0x00,0x07,0x10,0x33,0x41,0x41,0x5A,0xFF.
REQ-037 SEND with tx_ready toggling 1/0 -> tx_data stable while stalled; exactly 8 transfers; no byte duplicated or skipped.
REQ-038 rx_valid during WAIT and during SEND -> overrun=1, output frame unchanged; next frame starts at slot 0.
REQ-039 Sorter that never asserts done -> timeout=1 after exactly 1024 WAIT cycles; tx_valid never asserted; FILL accepts a new frame.
REQ-040 rst asserted after 3 of 8 bytes, then released -> all outputs 0; the next 8 bytes form a complete frame.
REQ-041 sort_done in the 1024th WAIT cycle -> result sent; timeout stays 0.
